// File: rtl/rom_cache_assoc_pkg.sv
// Shared constants and the FSM state type for the set-associative ROM cache.
package rom_cache_assoc_pkg;

    // Byte offset of the CPU ROM image inside SDRAM
    localparam logic [31:0] CPU_ROM_SDR_BASE = 32'h0010_0000;

    typedef enum logic [2:0] {
        StResync,
        StIdle,
        StLookup,
        StFill,
        StReady,
        StBump,
        StSweep
    } rom_cache_state_t;

endpackage

// File: rtl/rom_cache_way.sv
// One cache way: tag RAM and 64-bit line RAM, registered read port, single write port.
module rom_cache_way #(
    parameter int unsigned SETS_LOG2 = 8,
    parameter int unsigned ENTRY_W   = 16
) (
    input  logic                 i_clk,
    input  logic [SETS_LOG2-1:0] i_rd_set,
    output logic [ENTRY_W-1:0]   o_rd_entry,
    output logic [63:0]          o_rd_line,
    input  logic                 i_wr_en,
    input  logic [SETS_LOG2-1:0] i_wr_set,
    input  logic [ENTRY_W-1:0]   i_wr_entry,
    input  logic [63:0]          i_wr_line
);

    localparam int unsigned SETS = 2 ** SETS_LOG2;

    logic [ENTRY_W-1:0] r_tag_ram  [SETS];
    logic [63:0]        r_data_ram [SETS];
    logic [ENTRY_W-1:0] r_rd_entry;
    logic [63:0]        r_rd_line;

    // Write port plus registered read of the addressed set (no reset: plain RAM)
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_tag_ram[i_wr_set]  <= i_wr_entry;
            r_data_ram[i_wr_set] <= i_wr_line;
        end
        r_rd_entry <= r_tag_ram[i_rd_set];
        r_rd_line  <= r_data_ram[i_rd_set];
    end

    assign o_rd_entry = r_rd_entry;
    assign o_rd_line  = r_rd_line;

endmodule

// File: rtl/rom_cache_assoc.sv
// Set-associative read-only cache between a 68k-style ROM bus and the SDRAM arbiter.
// Lines are four 16-bit words; word k lives in line bits [16k+15:16k].
module rom_cache_assoc
    import rom_cache_assoc_pkg::*;
#(
    parameter int unsigned            SETS_LOG2  = 8,
    parameter int unsigned            WAYS       = 2,
    parameter int unsigned            ADDR_W     = 23,
    parameter int unsigned            SDR_ADDR_W = 27,
    parameter logic [SDR_ADDR_W-1:0]  SDR_BASE   = CPU_ROM_SDR_BASE[SDR_ADDR_W-1:0],
    parameter int unsigned            GEN_W      = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_flush,
    output logic [SDR_ADDR_W-1:0] o_sdr_addr,
    input  logic [63:0]           i_sdr_data,
    output logic                  o_sdr_req,
    input  logic                  i_sdr_ack,
    input  logic                  i_as_n,
    output logic                  o_dtack_n,
    input  logic [ADDR_W-1:0]     i_cpu_addr,
    output logic [15:0]           o_data
);

    localparam int unsigned TAG_W   = ADDR_W - SETS_LOG2 - 2;
    localparam int unsigned ENTRY_W = 1 + GEN_W + TAG_W;
    localparam int unsigned SETS    = 2 ** SETS_LOG2;

    rom_cache_state_t      r_state;
    logic [GEN_W-1:0]      r_gen;
    logic                  r_flush_pend;
    logic [SETS_LOG2-1:0]  r_sweep_set;
    logic [SETS_LOG2-1:0]  r_set;
    logic [TAG_W-1:0]      r_tag;
    logic                  r_victim;
    logic [63:0]           r_line;
    logic                  r_sdr_req;
    logic                  r_dtack_n;
    logic [SDR_ADDR_W-1:0] r_sdr_addr;

    logic [SETS_LOG2-1:0]  w_cpu_set;
    logic [TAG_W-1:0]      w_cpu_tag;
    logic [ENTRY_W-1:0]    w_lookup_entry;
    logic [GEN_W-1:0]      w_gen_next;
    logic                  w_ack_match;
    logic [ENTRY_W-1:0]    w_rd_entry [WAYS];
    logic [63:0]           w_rd_line  [WAYS];
    logic                  w_hit;
    logic                  w_hit_way;
    logic [63:0]           w_hit_line;
    logic                  w_found_inv;
    logic                  w_victim;
    logic                  w_lru_rd;
    logic                  w_lru_we;
    logic [SETS_LOG2-1:0]  w_lru_set;
    logic                  w_lru_val;
    logic [WAYS-1:0]       w_wr_en;
    logic [SETS_LOG2-1:0]  w_wr_set;
    logic [ENTRY_W-1:0]    w_wr_entry;
    logic [63:0]           w_wr_line;

    assign w_cpu_set      = i_cpu_addr[SETS_LOG2+1:2];
    assign w_cpu_tag      = i_cpu_addr[ADDR_W-1:SETS_LOG2+2];
    assign w_lookup_entry = {1'b1, r_gen, w_cpu_tag};
    assign w_gen_next     = r_gen + 1'b1;
    assign w_ack_match    = (i_sdr_ack == r_sdr_req);

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        rom_cache_way #(
            .SETS_LOG2 (SETS_LOG2),
            .ENTRY_W   (ENTRY_W)
        ) u_way (
            .i_clk      (i_clk),
            .i_rd_set   (w_cpu_set),
            .o_rd_entry (w_rd_entry[g]),
            .o_rd_line  (w_rd_line[g]),
            .i_wr_en    (w_wr_en[g]),
            .i_wr_set   (w_wr_set),
            .i_wr_entry (w_wr_entry),
            .i_wr_line  (w_wr_line)
        );
    end

    // Tag compare across ways and victim choice (first invalid way, else LRU)
    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = 1'b0;
        w_hit_line  = '0;
        w_found_inv = 1'b0;
        w_victim    = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!w_hit && w_rd_entry[w] == w_lookup_entry) begin
                w_hit      = 1'b1;
                w_hit_way  = 1'(w);
                w_hit_line = w_rd_line[w];
            end
            if (!w_found_inv && !w_rd_entry[w][ENTRY_W-1]) begin
                w_found_inv = 1'b1;
                w_victim    = 1'(w);
            end
        end
        if (!w_found_inv) begin
            w_victim = w_lru_rd;
        end
    end

    // LRU points at the way not most recently used, on hits and on fills
    always_comb begin
        w_lru_we  = 1'b0;
        w_lru_set = r_set;
        w_lru_val = ~r_victim;
        if (r_state == StLookup && w_hit) begin
            w_lru_we  = 1'b1;
            w_lru_set = w_cpu_set;
            w_lru_val = ~w_hit_way;
        end else if (r_state == StFill && w_ack_match) begin
            w_lru_we = 1'b1;
        end
    end

    if (WAYS == 2) begin : g_lru
        logic [SETS-1:0] r_lru;

        // Per-set LRU bit
        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                r_lru <= '0;
            end else if (w_lru_we) begin
                r_lru[w_lru_set] <= w_lru_val;
            end
        end

        assign w_lru_rd = r_lru[w_cpu_set];
    end else begin : g_no_lru
        assign w_lru_rd = 1'b0;
    end

    // Shared RAM write port: sweep clears whole entries, fill writes the victim way
    always_comb begin
        w_wr_en    = '0;
        w_wr_set   = r_set;
        w_wr_entry = {1'b1, r_gen, r_tag};
        w_wr_line  = i_sdr_data;
        if (r_state == StSweep) begin
            w_wr_en    = '1;
            w_wr_set   = r_sweep_set;
            w_wr_entry = '0;
            w_wr_line  = '0;
        end else if (r_state == StFill && w_ack_match) begin
            for (int w = 0; w < WAYS; w++) begin
                w_wr_en[w] = (r_victim == 1'(w));
            end
        end
    end

    // Generation counter survives reset so tags written before reset cannot alias
    always_ff @(posedge i_clk) begin
        if (r_state == StBump) begin
            r_gen <= w_gen_next;
        end
    end

    // Main control FSM with registered bus outputs
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= StResync;
            r_flush_pend <= 1'b1;
            r_sweep_set  <= '0;
            r_set        <= '0;
            r_tag        <= '0;
            r_victim     <= 1'b0;
            r_line       <= '0;
            r_sdr_req    <= 1'b0;
            r_dtack_n    <= 1'b1;
            r_sdr_addr   <= '0;
        end else begin
            if (i_flush) begin
                r_flush_pend <= 1'b1;
            end
            unique case (r_state)
                StResync: begin
                    if (w_ack_match) begin
                        r_state <= StIdle;
                    end
                end
                StIdle: begin
                    r_dtack_n <= 1'b1;
                    // A flush in the same cycle as the strobe wins
                    if (r_flush_pend || i_flush) begin
                        r_flush_pend <= 1'b0;
                        r_state      <= StBump;
                    end else if (!i_as_n) begin
                        r_state <= StLookup;
                    end
                end
                StLookup: begin
                    r_set <= w_cpu_set;
                    r_tag <= w_cpu_tag;
                    if (w_hit) begin
                        r_line  <= w_hit_line;
                        r_state <= StReady;
                    end else begin
                        r_victim   <= w_victim;
                        r_sdr_addr <= SDR_BASE +
                                      SDR_ADDR_W'({i_cpu_addr[ADDR_W-1:2], 3'b000});
                        r_sdr_req  <= ~r_sdr_req;
                        r_state    <= StFill;
                    end
                end
                StFill: begin
                    if (w_ack_match) begin
                        r_line  <= i_sdr_data;
                        r_state <= StReady;
                    end
                end
                StReady: begin
                    // dtack always shows for at least one cycle, even if the strobe already left
                    if (!r_dtack_n && i_as_n) begin
                        r_dtack_n <= 1'b1;
                        r_state   <= StIdle;
                    end else begin
                        r_dtack_n <= 1'b0;
                    end
                end
                StBump: begin
                    r_sweep_set <= '0;
                    r_state     <= (w_gen_next == '0) ? StSweep : StIdle;
                end
                StSweep: begin
                    r_sweep_set <= r_sweep_set + 1'b1;
                    if (&r_sweep_set) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StResync;
            endcase
        end
    end

    // Word select from the held line
    always_comb begin
        unique case (i_cpu_addr[1:0])
            2'd0: o_data = r_line[15:0];
            2'd1: o_data = r_line[31:16];
            2'd2: o_data = r_line[47:32];
            2'd3: o_data = r_line[63:48];
            default: o_data = r_line[15:0];
        endcase
    end

    assign o_sdr_addr = r_sdr_addr;
    assign o_sdr_req  = r_sdr_req;
    assign o_dtack_n  = r_dtack_n;

endmodule
